write_collision_arbiter: RTL

Per-cell write collision detector and resolver for the multi-port RAM, generalising single-cycle "all agents hit" detection to N agents with arbitration. Each cycle it finds every write agent targeting `cell_addr`, picks one winner (fixed or round-robin priority), and registers the winning write towards the storage cell. It also reports hit count, collision pulse, saturating collision counter and sticky flag to status logic. One instance sits in front of each memory cell.

---
 rtl/write_collision_arbiter_if.sv | 37 +++
 rtl/write_collision_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/write_collision_arbiter_if.sv
// Write-port bundle between the write agents and one per-cell collision arbiter.
// The master side drives agent requests; the slave side (the arbiter) returns
// the resolved cell write and collision status.
interface write_collision_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NB_WRAGENT = 4,
    parameter int unsigned CNT_WIDTH  = 16
);
    localparam int unsigned HC_WIDTH = $clog2(NB_WRAGENT + 1);

    logic [ADDR_WIDTH-1:0]            cell_addr;
    logic [NB_WRAGENT-1:0]            wren;
    logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr;
    logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata;
    logic                             collision_clr;

    logic                             cell_wren;
    logic [DATA_WIDTH-1:0]            cell_wrdata;
    logic [NB_WRAGENT-1:0]            grant;
    logic [HC_WIDTH-1:0]              hit_count;
    logic                             collision;
    logic [CNT_WIDTH-1:0]             collision_cnt;
    logic                             collision_flag;

    modport master (
        output cell_addr, wren, wraddr, wrdata, collision_clr,
        input  cell_wren, cell_wrdata, grant, hit_count, collision,
               collision_cnt, collision_flag
    );

    modport slave (
        input  cell_addr, wren, wraddr, wrdata, collision_clr,
        output cell_wren, cell_wrdata, grant, hit_count, collision,
               collision_cnt, collision_flag
    );
endinterface

// File: rtl/write_collision_arbiter.sv
// Per-cell write collision detector/resolver. Finds every agent writing this
// cell's address, picks one winner (fixed or round-robin priority), registers
// the winning write and reports hit count, collision pulse, a saturating
// collision counter and a sticky collision flag. All outputs come from flops.
module write_collision_arbiter #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NB_WRAGENT = 4,
    parameter int unsigned MODE       = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    write_collision_arbiter_if.slave bus
);
    localparam int          NB       = int'(NB_WRAGENT);
    localparam int unsigned HC_WIDTH = $clog2(NB_WRAGENT + 1);
    localparam int unsigned PTR_W    = $clog2(NB_WRAGENT);

    logic [NB_WRAGENT-1:0] hit;
    logic [HC_WIDTH-1:0]   hit_cnt;
    logic                  coll;
    logic                  win_found;
    logic [PTR_W-1:0]      win_idx;
    logic [PTR_W-1:0]      rr_ptr_d, rr_ptr_q;
    logic [NB_WRAGENT-1:0] grant_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic                  flag_d;
    int                    scan;

    logic                  cell_wren_q;
    logic [DATA_WIDTH-1:0] cell_wrdata_q;
    logic [NB_WRAGENT-1:0] grant_q;
    logic [HC_WIDTH-1:0]   hit_count_q;
    logic                  collision_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  flag_q;

    // Address match per agent and population count of the hits.
    always_comb begin
        hit     = '0;
        hit_cnt = '0;
        for (int i = 0; i < NB; i++) begin
            hit[i]  = bus.wren[i] && (bus.wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == bus.cell_addr);
            hit_cnt = hit_cnt + HC_WIDTH'(hit[i]);
        end
        coll = (hit_cnt >= HC_WIDTH'(2));
    end

    // Winner selection: lowest index, or first hit scanning up from rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = 0;
        for (int k = 0; k < NB; k++) begin
            if (MODE == 1) begin
                scan = int'(rr_ptr_q) + k;
                if (scan >= NB) begin
                    scan = scan - NB;
                end
            end else begin
                scan = k;
            end
            if (!win_found && hit[scan]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(scan);
            end
        end
    end

    // Grant/data mux, round-robin pointer advance and counter/flag next state.
    always_comb begin
        grant_d  = '0;
        data_d   = '0;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        flag_d   = flag_q;
        for (int i = 0; i < NB; i++) begin
            if (win_found && (win_idx == PTR_W'(i))) begin
                grant_d[i] = 1'b1;
                data_d     = bus.wrdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if ((MODE == 1) && win_found) begin
            // Explicit wrap keeps non-power-of-2 agent counts in range.
            rr_ptr_d = (win_idx == PTR_W'(NB - 1)) ? '0 : win_idx + PTR_W'(1);
        end
        if (coll) begin
            // A collision in the clear cycle is counted after the clear.
            if (bus.collision_clr) begin
                cnt_d = CNT_WIDTH'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            flag_d = 1'b1;
        end else if (bus.collision_clr) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end
    end

    // Output and pointer registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cell_wren_q   <= 1'b0;
            cell_wrdata_q <= '0;
            grant_q       <= '0;
            hit_count_q   <= '0;
            collision_q   <= 1'b0;
            cnt_q         <= '0;
            flag_q        <= 1'b0;
            rr_ptr_q      <= '0;
        end else begin
            cell_wren_q   <= |hit;
            cell_wrdata_q <= data_d;
            grant_q       <= grant_d;
            hit_count_q   <= hit_cnt;
            collision_q   <= coll;
            cnt_q         <= cnt_d;
            flag_q        <= flag_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign bus.cell_wren      = cell_wren_q;
    assign bus.cell_wrdata    = cell_wrdata_q;
    assign bus.grant          = grant_q;
    assign bus.hit_count      = hit_count_q;
    assign bus.collision      = collision_q;
    assign bus.collision_cnt  = cnt_q;
    assign bus.collision_flag = flag_q;
endmodule
